mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 31 +++
 rtl/mem_responder_mem_array.sv | 28 ++
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: widths, FSM state codes,
// the latched request payload and the storage address-decode helper.
package mem_responder_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LED_W  = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [ADDR_W-1:0] LED_ADDR_DEFAULT = 16'hFF00;

    // Responder FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Request payload as captured on accept
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // True when the word address falls inside a 2**aw word storage array;
    // any set bit above aw rejects the address so nothing aliases.
    function automatic logic in_storage(input logic [ADDR_W-1:0] addr,
                                        input int unsigned aw);
        return (addr >> aw) == ADDR_W'(0);
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM, 2**AW x 16 bit, no reset on contents.
// Ports: clk, we (write enable), addr (word address), wdata, rdata
// (registered read of addr, old contents on a write cycle).
module mem_responder_mem_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and registered read share the single address port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// CPU-side memory responder: one outstanding request, optional wait states,
// word storage plus a memory-mapped LED register, error on unmapped access.
// Ports: clk, rst_n (async active-low); request channel req_valid/req_ready
// with req_we, req_addr, req_wdata; response channel rsp_valid/rsp_ready with
// rsp_rdata, rsp_err; leds (LED register contents).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned       AW          = 10,
    parameter int unsigned       WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] LED_ADDR    = LED_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [LED_W-1:0]  leds
);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    mem_req_t          req_q;
    mem_req_t          cur;
    logic              accept;
    logic              enter_resp;
    logic              cur_mem;
    logic              cur_led;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              sel_mem_q;
    logic [DATA_W-1:0] rdata_q;

    assign accept = req_valid & req_ready;

    // Live request in IDLE (zero-wait accept enters RESP directly), latched one otherwise
    always_comb begin
        cur = req_q;
        if (state == ST_IDLE) begin
            cur = '{we: req_we, addr: req_addr, wdata: req_wdata};
        end
    end

    assign cur_mem = in_storage(cur.addr, AW);
    assign cur_led = !cur_mem && (cur.addr == LED_ADDR);

    // Next-state and wait counter
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_next = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Side effects and response capture all happen on the RESP-entry edge
    assign enter_resp = (state_next == ST_RESP) && (state != ST_RESP);
    assign mem_we     = enter_resp && cur.we && cur_mem;
    assign mem_addr   = cur.addr[AW-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            req_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                req_q <= cur;
            end
        end
    end

    // Registered handshake, response and LED outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            sel_mem_q <= 1'b0;
            rdata_q   <= '0;
            leds      <= '0;
        end else begin
            req_ready <= (state_next == ST_IDLE);
            rsp_valid <= (state_next == ST_RESP);
            if (enter_resp) begin
                rsp_err   <= !(cur_mem || cur_led);
                sel_mem_q <= cur_mem && !cur.we;
                rdata_q   <= (cur_led && !cur.we) ? {8'h00, leds} : DATA_W'(0);
                if (cur_led && cur.we) begin
                    leds <= cur.wdata[LED_W-1:0];
                end
            end
        end
    end

    // RAM output register is read directly; its address is held while in RESP,
    // so the selected read data stays stable until the response is taken.
    assign rsp_rdata = sel_mem_q ? mem_rdata : rdata_q;

    mem_responder_mem_array #(
        .AW(AW)
    ) u_mem_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(cur.wdata),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_STATES 0, 1, 3) sharing clock
// and reset, directed scenarios plus randomized traffic against a simple
// address-map reference model.
module tb_mem_responder;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [N];
    logic        req_we    [N];
    logic [15:0] req_addr  [N];
    logic [15:0] req_wdata [N];
    logic        req_ready [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [15:0] rsp_rdata [N];
    logic        rsp_err   [N];
    logic [7:0]  leds      [N];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [15:0] mem_m   [N][1024];
    bit          known_m [N][1024];
    logic [7:0]  leds_m  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        mem_responder #(
            .AW(10),
            .WAIT_STATES(WS),
            .LED_ADDR(16'hFF00)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_valid(req_valid[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_ready(req_ready[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g]),
            .leds     (leds[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    // Address map: 0..1023 storage, 0xFF00 LED register, everything else errors
    task automatic model_access(input int k, input bit we, input logic [15:0] addr,
                                input logic [15:0] wdata, output logic [15:0] exp_rd,
                                output logic exp_err, output bit rd_known);
        rd_known = 1'b1;
        exp_rd   = 16'h0000;
        exp_err  = 1'b0;
        if (addr < 16'd1024) begin
            if (we) begin
                mem_m[k][addr[9:0]]   = wdata;
                known_m[k][addr[9:0]] = 1'b1;
            end else begin
                exp_rd   = mem_m[k][addr[9:0]];
                rd_known = known_m[k][addr[9:0]];
            end
        end else if (addr == 16'hFF00) begin
            if (we) leds_m[k] = wdata[7:0];
            else    exp_rd = {8'h00, leds_m[k]};
        end else begin
            exp_err = 1'b1;
        end
    endtask

    // One complete transaction; lat = cycles from accept to first rsp_valid
    task automatic txn(input int k, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata, input int hold, output int lat,
                       output logic [15:0] rd, output logic err, output bit stable);
        int n;
        lat = -1; rd = 16'hxxxx; err = 1'bx; stable = 1'b0;
        @(negedge clk);
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
        req_wdata[k] = wdata; rsp_ready[k] = 1'b0;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            n_checks++;
            $display("FAIL txn_accept_timeout inst=%0d: req_ready=%b want 1", k, req_ready[k]);
            req_valid[k] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[k] = 1'b0;
        n = 1;
        while (rsp_valid[k] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            n_checks++;
            $display("FAIL txn_rsp_timeout inst=%0d: rsp_valid=%b want 1", k, rsp_valid[k]);
            return;
        end
        lat = n; rd = rsp_rdata[k]; err = rsp_err[k]; stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (rsp_valid[k] !== 1'b1 || rsp_rdata[k] !== rd || rsp_err[k] !== err) stable = 1'b0;
        end
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 16'h0;
            req_wdata[k] = 16'h0; rsp_ready[k] = 1'b0; leds_m[k] = 8'h00;
            for (int a = 0; a < 1024; a++) known_m[k][a] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if ({req_ready[k], rsp_valid[k], rsp_err[k], rsp_rdata[k], leds[k]} !== {1'b1, 1'b0, 1'b0, 16'h0000, 8'h00})
                $display("FAIL reset_state inst=%0d: rdy=%b vld=%b err=%b rdata=%h leds=%h want 1 0 0 0000 00",
                         k, req_ready[k], rsp_valid[k], rsp_err[k], rsp_rdata[k], leds[k]);
            else n_pass++;
        end
    endtask

    task automatic test_mem_rw();
        int lat; logic [15:0] rd, er; logic err, ee; bit st, kn;
        txn(1, 1'b1, 16'h0005, 16'hBEEF, 0, lat, rd, err, st);
        model_access(1, 1'b1, 16'h0005, 16'hBEEF, er, ee, kn);
        n_checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== 16'h0000)
            $display("FAIL mem_write: lat=%0d err=%b rdata=%h want 2 0 0000", lat, err, rd);
        else n_pass++;
        txn(1, 1'b0, 16'h0005, 16'h0, 0, lat, rd, err, st);
        n_checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== 16'hBEEF)
            $display("FAIL mem_read: lat=%0d err=%b rdata=%h want 2 0 beef", lat, err, rd);
        else n_pass++;
    endtask

    task automatic test_led();
        int lat; logic [15:0] rd, er; logic err, ee; bit st, kn;
        txn(0, 1'b1, 16'hFF00, 16'h00A5, 0, lat, rd, err, st);
        model_access(0, 1'b1, 16'hFF00, 16'h00A5, er, ee, kn);
        n_checks++;
        if (lat !== 1 || err !== 1'b0 || leds[0] !== 8'hA5)
            $display("FAIL led_write: lat=%0d err=%b leds=%h want 1 0 a5", lat, err, leds[0]);
        else n_pass++;
        txn(0, 1'b0, 16'hFF00, 16'h0, 0, lat, rd, err, st);
        n_checks++;
        if (lat !== 1 || err !== 1'b0 || rd !== 16'h00A5)
            $display("FAIL led_read: lat=%0d err=%b rdata=%h want 1 0 00a5", lat, err, rd);
        else n_pass++;
    endtask

    task automatic test_unmapped();
        int lat; logic [15:0] rd, er; logic err, ee; bit st, kn;
        txn(1, 1'b1, 16'h0000, 16'h1111, 0, lat, rd, err, st);
        model_access(1, 1'b1, 16'h0000, 16'h1111, er, ee, kn);
        txn(1, 1'b0, 16'h8000, 16'h0, 0, lat, rd, err, st);
        n_checks++;
        if (err !== 1'b1 || rd !== 16'h0000)
            $display("FAIL unmapped_read_8000: err=%b rdata=%h want 1 0000", err, rd);
        else n_pass++;
        txn(1, 1'b1, 16'h0400, 16'hFFFF, 0, lat, rd, err, st);
        n_checks++;
        if (err !== 1'b1) $display("FAIL unmapped_write_0400: err=%b want 1", err);
        else n_pass++;
        txn(1, 1'b1, 16'hFF01, 16'h00FF, 0, lat, rd, err, st);
        n_checks++;
        if (err !== 1'b1 || leds[1] !== leds_m[1])
            $display("FAIL unmapped_write_ff01: err=%b leds=%h want 1 %h", err, leds[1], leds_m[1]);
        else n_pass++;
        txn(1, 1'b0, 16'h0000, 16'h0, 0, lat, rd, err, st);
        n_checks++;
        if (err !== 1'b0 || rd !== 16'h1111)
            $display("FAIL word0_unchanged: err=%b rdata=%h want 0 1111", err, rd);
        else n_pass++;
    endtask

    task automatic test_hold();
        int lat, n; logic [15:0] rd, er; logic err, ee; bit st, kn, ok;
        txn(1, 1'b1, 16'h0020, 16'hC0DE, 0, lat, rd, err, st);
        model_access(1, 1'b1, 16'h0020, 16'hC0DE, er, ee, kn);
        txn(1, 1'b1, 16'h0021, 16'h0BAD, 0, lat, rd, err, st);
        model_access(1, 1'b1, 16'h0021, 16'h0BAD, er, ee, kn);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 16'h0020; rsp_ready[1] = 1'b0;
        @(negedge clk);
        // Next request presented and held while the first is outstanding
        req_we[1] = 1'b1; req_addr[1] = 16'h0021; req_wdata[1] = 16'hDEAD;
        n = 1;
        while (rsp_valid[1] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        rd = rsp_rdata[1];
        n_checks++;
        if (n >= 20 || rd !== 16'hC0DE)
            $display("FAIL hold_first_rdata: rsp_valid=%b rdata=%h want 1 c0de", rsp_valid[1], rd);
        else n_pass++;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 16'hC0DE || req_ready[1] !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (ok !== 1'b1)
            $display("FAIL hold_stable: vld=%b rdata=%h rdy=%b want 1 c0de 0", rsp_valid[1], rsp_rdata[1], req_ready[1]);
        else n_pass++;
        rsp_ready[1] = 1'b1; req_valid[1] = 1'b0;
        @(negedge clk);
        rsp_ready[1] = 1'b0;
        n_checks++;
        if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1)
            $display("FAIL hold_release: vld=%b rdy=%b want 0 1", rsp_valid[1], req_ready[1]);
        else n_pass++;
        txn(1, 1'b0, 16'h0021, 16'h0, 0, lat, rd, err, st);
        n_checks++;
        if (rd !== 16'h0BAD)
            $display("FAIL hold_no_second_accept: rdata=%h want 0bad", rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] rd, er; logic err, ee; bit st, kn;
        txn(2, 1'b1, 16'h0010, 16'h5555, 0, lat, rd, err, st);
        model_access(2, 1'b1, 16'h0010, 16'h5555, er, ee, kn);
        txn(2, 1'b1, 16'hFF00, 16'h003C, 0, lat, rd, err, st);
        model_access(2, 1'b1, 16'hFF00, 16'h003C, er, ee, kn);
        n_checks++;
        if (lat !== 4 || leds[2] !== 8'h3C)
            $display("FAIL ws3_led_write: lat=%0d leds=%h want 4 3c", lat, leds[2]);
        else n_pass++;
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 16'h0010; req_wdata[2] = 16'h1234;
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) leds_m[k] = 8'h00;
        @(negedge clk);
        n_checks++;
        if (leds[2] !== 8'h00 || req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0)
            $display("FAIL reset_mid_state: leds=%h rdy=%b vld=%b want 00 1 0", leds[2], req_ready[2], rsp_valid[2]);
        else n_pass++;
        repeat (5) @(negedge clk);
        txn(2, 1'b0, 16'h0010, 16'h0, 0, lat, rd, err, st);
        n_checks++;
        if (rd !== 16'h5555 || err !== 1'b0)
            $display("FAIL reset_mid_write_dropped: rdata=%h err=%b want 5555 0", rd, err);
        else n_pass++;
    endtask

    task automatic test_wrap_ends();
        int lat; logic [15:0] rd, er; logic err, ee; bit st, kn;
        txn(1, 1'b1, 16'h0000, 16'hA1A1, 0, lat, rd, err, st);
        model_access(1, 1'b1, 16'h0000, 16'hA1A1, er, ee, kn);
        txn(1, 1'b1, 16'h03FF, 16'h5E5E, 0, lat, rd, err, st);
        model_access(1, 1'b1, 16'h03FF, 16'h5E5E, er, ee, kn);
        txn(1, 1'b0, 16'h0000, 16'h0, 0, lat, rd, err, st);
        n_checks++;
        if (rd !== 16'hA1A1) $display("FAIL wrap_low: rdata=%h want a1a1", rd);
        else n_pass++;
        txn(1, 1'b0, 16'h03FF, 16'h0, 0, lat, rd, err, st);
        n_checks++;
        if (rd !== 16'h5E5E || err !== 1'b0) $display("FAIL wrap_high: rdata=%h err=%b want 5e5e 0", rd, err);
        else n_pass++;
    endtask

    // Request held continuously with rsp_ready high: each transaction must
    // cost one IDLE cycle plus WAIT_STATES plus one RESP cycle.
    task automatic test_back_to_back();
        int ws, nresp; bit ok;
        for (int k = 0; k < N; k++) begin
            ws = ws_of(k);
            nresp = 0; ok = 1'b1;
            @(negedge clk);
            req_valid[k] = 1'b1; req_we[k] = 1'b0; req_addr[k] = 16'hFF00; rsp_ready[k] = 1'b1;
            for (int c = 0; c < 4 * (ws + 2); c++) begin
                if (c != 0) @(negedge clk);
                if (rsp_valid[k] === 1'b1) begin
                    nresp++;
                    if (rsp_rdata[k] !== {8'h00, leds_m[k]} || req_ready[k] !== 1'b0) ok = 1'b0;
                end
            end
            req_valid[k] = 1'b0;
            @(negedge clk);
            rsp_ready[k] = 1'b0;
            n_checks++;
            if (nresp !== 4 || ok !== 1'b1)
                $display("FAIL back_to_back inst=%0d: responses=%0d data_ok=%b want 4 1", k, nresp, ok);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int lat, hold, sel; logic [15:0] rd, er, addr, wd; logic err, ee; bit st, kn, we;
        for (int k = 0; k < N; k++) begin
            for (int a = 0; a < 9; a++) begin
                addr = (a == 8) ? 16'h03FF : 16'(a);
                wd = 16'($urandom);
                txn(k, 1'b1, addr, wd, 0, lat, rd, err, st);
                model_access(k, 1'b1, addr, wd, er, ee, kn);
            end
            for (int i = 0; i < 30; i++) begin
                sel = $urandom_range(0, 9);
                if (sel <= 5) begin
                    addr = 16'($urandom_range(0, 8));
                    if (addr == 16'd8) addr = 16'h03FF;
                end else if (sel <= 7) addr = 16'hFF00;
                else if (sel == 8) addr = 16'($urandom_range(16'h0400, 16'hFEFF));
                else addr = 16'($urandom_range(16'hFF01, 16'hFFFF));
                we   = 1'($urandom_range(0, 1));
                wd   = 16'($urandom);
                hold = $urandom_range(0, 3);
                txn(k, we, addr, wd, hold, lat, rd, err, st);
                model_access(k, we, addr, wd, er, ee, kn);
                n_checks++;
                if (lat !== ws_of(k) + 1 || err !== ee)
                    $display("FAIL rand_lat_err inst=%0d addr=%h we=%b: lat=%0d err=%b want %0d %b",
                             k, addr, we, lat, err, ws_of(k) + 1, ee);
                else n_pass++;
                if (kn) begin
                    n_checks++;
                    if (rd !== er)
                        $display("FAIL rand_rdata inst=%0d addr=%h we=%b: rdata=%h want %h", k, addr, we, rd, er);
                    else n_pass++;
                end
                if (hold > 0) begin
                    n_checks++;
                    if (st !== 1'b1) $display("FAIL rand_stable inst=%0d addr=%h: stable=%b want 1", k, addr, st);
                    else n_pass++;
                end
                n_checks++;
                if (leds[k] !== leds_m[k])
                    $display("FAIL rand_leds inst=%0d: leds=%h want %h", k, leds[k], leds_m[k]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mem_rw();
        test_led();
        test_unmapped();
        test_hold();
        test_reset_mid();
        test_wrap_ends();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1);
    end

endmodule
